// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding request/response
// handshake with instruction memory and drives the IF/ID pipeline register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc,
  output logic        IF_ID_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic [31:0] hold_inst_q;
  logic [31:0] hold_pc_q;
  logic        discard_q;

  logic [31:0] redirect_target;
  logic        accept;
  logic        resp_live;
  logic        deliver_now;
  logic [31:0] deliver_inst;
  logic [31:0] deliver_pc;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // A follow-on request is only issued in WAIT when the live response is
  // consumed immediately, keeping at most one request in flight.
  assign imem_req = rst_n && !redirect_valid &&
                    ((state_q == ST_IDLE) ||
                     ((state_q == ST_WAIT) && imem_rvalid && !discard_q && !stall));
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;

  assign resp_live    = (state_q == ST_WAIT) && imem_rvalid && !discard_q;
  assign deliver_now  = !redirect_valid && !stall && (resp_live || (state_q == ST_HOLD));
  assign deliver_inst = (state_q == ST_HOLD) ? hold_inst_q : imem_rdata;
  assign deliver_pc   = (state_q == ST_HOLD) ? hold_pc_q   : req_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= 32'h0;
      hold_inst_q <= 32'h0;
      hold_pc_q   <= 32'h0;
      discard_q   <= 1'b0;
      IF_ID_inst  <= NOP_INST;
      IF_ID_pc    <= 32'h0;
      IF_ID_valid <= 1'b0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_target;
      hold_inst_q <= 32'h0;
      hold_pc_q   <= 32'h0;
      IF_ID_inst  <= NOP_INST;
      IF_ID_valid <= 1'b0;
      case (state_q)
        ST_WAIT: begin
          // Without a response this cycle the old fetch is still in flight and
          // must be thrown away when it finally returns.
          if (imem_rvalid) begin
            state_q   <= ST_IDLE;
            discard_q <= 1'b0;
          end else begin
            discard_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          discard_q <= 1'b0;
        end
      endcase
    end else begin
      if (accept) begin
        pc_q       <= pc_q + 32'd4;
        req_addr_q <= pc_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= ST_IDLE;
            end else if (!stall) begin
              state_q <= accept ? ST_WAIT : ST_IDLE;
            end else begin
              hold_inst_q <= imem_rdata;
              hold_pc_q   <= req_addr_q;
              state_q     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (!stall) begin
        if (deliver_now) begin
          IF_ID_inst  <= deliver_inst;
          IF_ID_pc    <= deliver_pc;
          IF_ID_valid <= 1'b1;
        end else begin
          IF_ID_inst  <= NOP_INST;
          IF_ID_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by random
// traffic, compared against a transaction-level model of the fetch stage.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] SALT   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] IF_ID_inst;
  logic [31:0] IF_ID_pc;
  logic        IF_ID_valid;

  int n_cmp = 0;
  int n_fail = 0;

  // Transaction-level model: one optional in-flight fetch, one optional parked instruction.
  logic [31:0] m_pc;
  logic        m_busy;
  logic [31:0] m_req_addr;
  logic        m_doomed;
  logic        m_held;
  logic [31:0] m_held_pc;
  logic [31:0] m_held_inst;
  logic [31:0] m_inst;
  logic [31:0] m_ifpc;
  logic        m_valid;

  logic [31:0] acc_log[$];
  logic [31:0] deliv_pc[$];
  logic [31:0] deliv_inst[$];

  if_fetch_unit #(
    .RESET_PC(RST_PC),
    .NOP_INST(NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .IF_ID_inst    (IF_ID_inst),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_valid   (IF_ID_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic modelReset();
    m_pc = RST_PC; m_busy = 1'b0; m_req_addr = 32'h0; m_doomed = 1'b0;
    m_held = 1'b0; m_held_pc = 32'h0; m_held_inst = 32'h0;
    m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
  endtask

  // Asserts reset asynchronously mid-cycle and keeps it for n rising edges.
  task automatic doReset(input int n);
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_req",   {31'b0, imem_req}, 32'h0);
    checkOutput("rst_addr",  imem_addr, RST_PC);
    checkOutput("rst_inst",  IF_ID_inst, NOP);
    checkOutput("rst_pc",    IF_ID_pc, 32'h0);
    checkOutput("rst_valid", {31'b0, IF_ID_valid}, 32'h0);
    repeat (n) @(posedge clk);
  endtask

  // One clock cycle: drive inputs, check the combinational request, advance model, check IF/ID.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic rdy, input logic rv);
    logic        exp_req;
    logic        dlv;
    logic [31:0] d_pc;
    logic [31:0] d_inst;
    dlv = 1'b0; d_pc = 32'h0; d_inst = 32'h0;
    @(negedge clk);
    rst_n = 1'b1; stall = st; redirect_valid = rd; redirect_pc = rpc;
    imem_ready = rdy; imem_rvalid = rv;
    imem_rdata = m_busy ? (m_req_addr ^ SALT) : $urandom();
    #1;
    exp_req = !rd && ((!m_busy && !m_held) || (m_busy && rv && !m_doomed && !st));
    checkOutput("imem_req",  {31'b0, imem_req}, {31'b0, exp_req});
    checkOutput("imem_addr", imem_addr, m_pc);
    if (imem_req && imem_ready) acc_log.push_back(imem_addr);

    if (rd) begin
      m_pc = {rpc[31:2], 2'b00};
      m_held = 1'b0;
      if (m_busy && !rv) m_doomed = 1'b1;
      else begin m_busy = 1'b0; m_doomed = 1'b0; end
      m_inst = NOP; m_valid = 1'b0;
    end else begin
      if (m_busy && rv) begin
        if (m_doomed) m_doomed = 1'b0;
        else if (!st) begin dlv = 1'b1; d_pc = m_req_addr; d_inst = imem_rdata; end
        else begin m_held = 1'b1; m_held_pc = m_req_addr; m_held_inst = imem_rdata; end
        m_busy = 1'b0;
      end else if (m_held && !st) begin
        dlv = 1'b1; d_pc = m_held_pc; d_inst = m_held_inst; m_held = 1'b0;
      end
      if (exp_req && rdy) begin
        m_req_addr = m_pc; m_pc = m_pc + 32'd4; m_busy = 1'b1;
      end
      if (!st) begin
        if (dlv) begin m_inst = d_inst; m_ifpc = d_pc; m_valid = 1'b1; end
        else begin m_inst = NOP; m_valid = 1'b0; end
      end
    end

    @(posedge clk);
    #1;
    checkOutput("if_inst",  IF_ID_inst, m_inst);
    checkOutput("if_pc",    IF_ID_pc, m_ifpc);
    checkOutput("if_valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
    if (!st && !rd && IF_ID_valid) begin
      deliv_pc.push_back(IF_ID_pc);
      deliv_inst.push_back(IF_ID_inst);
    end
  endtask

  initial begin
    modelReset();
    doReset(3);

    // Zero-wait stream from reset
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, m_busy);
    checkOutput("first_req",   qat(acc_log, 0), 32'h0000_0100);
    checkOutput("second_req",  qat(acc_log, 1), 32'h0000_0104);
    checkOutput("deliv_pc0",   qat(deliv_pc, 0), 32'h0000_0100);
    checkOutput("deliv_pc1",   qat(deliv_pc, 1), 32'h0000_0104);
    checkOutput("deliv_pc2",   qat(deliv_pc, 2), 32'h0000_0108);
    checkOutput("deliv_inst0", qat(deliv_inst, 0), 32'hA5A5_0100);
    checkOutput("deliv_inst2", qat(deliv_inst, 2), 32'hA5A5_0108);

    // Three-cycle stall mid-stream, then resume
    deliv_pc.delete(); deliv_inst.delete();
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, m_busy);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, m_busy);
    checkOutput("stall_resume0", qat(deliv_pc, 0), 32'h0000_0114);
    checkOutput("stall_resume1", qat(deliv_pc, 1), 32'h0000_0118);

    // Redirect in WAIT with the response arriving two cycles later
    acc_log.delete();
    applyStimulus(1'b0, 1'b1, 32'h0000_2002, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("late_resp_valid", {31'b0, IF_ID_valid}, 32'h0);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, m_busy);
    checkOutput("redir_req", qat(acc_log, 0), 32'h0000_2000);

    // Redirect coincident with a response while stalled
    acc_log.delete();
    applyStimulus(1'b1, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
    checkOutput("redir_stall_inst",  IF_ID_inst, NOP);
    checkOutput("redir_stall_valid", {31'b0, IF_ID_valid}, 32'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, m_busy);
    checkOutput("redir_stall_req", qat(acc_log, 0), 32'h0000_3000);

    // PC wrap at the top of the address space
    acc_log.delete();
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, m_busy);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, m_busy);
    checkOutput("wrap_req0", qat(acc_log, 0), 32'hFFFF_FFFC);
    checkOutput("wrap_req1", qat(acc_log, 1), 32'h0000_0000);

    // Reset while a fetch is outstanding, then a stray response
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, m_busy);
    doReset(2);
    acc_log.delete();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stray_valid", {31'b0, IF_ID_valid}, 32'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, m_busy);
    checkOutput("restart_req", qat(acc_log, 0), RST_PC);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic st, rd, rdy, rv;
      st  = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < 70);
      rv  = m_busy ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 5);
      applyStimulus(st, rd, $urandom(), rdy, rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the RISC-V pipeline. It holds the program counter, issues word fetches to instruction memory over a request/response handshake, and drives the IF/ID pipeline register (`IF_ID_inst`, `IF_ID_pc`, `IF_ID_valid`). The immediate generator and decoder read these outputs. Stall and flush from the hazard/branch logic are handled here; bubbles are inserted as canonical NOPs.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INST`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  ID stage cannot accept; hold the IF/ID register.
- `redirect_valid`  in  1  taken branch/jump; flush and load a new PC.
- `redirect_pc`  in  32  target PC; bits [1:0] ignored and treated as 0.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch word address; equals `pc_q`.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  fetched instruction.
- `IF_ID_inst`  out  32  instruction to decode.
- `IF_ID_pc`  out  32  PC of `IF_ID_inst`.
- `IF_ID_valid`  out  1  `IF_ID_inst` is a real instruction, not a bubble.

## Operation

- Reset values: `pc_q`=RESET_PC, state=IDLE, `discard`=0, hold buffer empty, `IF_ID_inst`=NOP_INST, `IF_ID_pc`=0, `IF_ID_valid`=0. `imem_req` is combinational and is 0 while `rst_n`=0.
- At most one outstanding request. A request is accepted when `imem_req && imem_ready`. On acceptance, the captured address is `pc_q`, and `pc_q <= pc_q + 4` (mod 2^32, so 0xFFFF_FFFC wraps to 0).
- `imem_req = !redirect_valid && (state==IDLE || (state==WAIT && imem_rvalid && !discard && !stall))`.
- States:
  - IDLE: no outstanding request. Accepted request -> WAIT. Otherwise stay in IDLE.
  - WAIT: request outstanding.
    - On `imem_rvalid` with `discard`=1: drop the data, clear `discard`, go to IDLE.
    - On `imem_rvalid` with `stall`=0: load the IF/ID register (valid=1, pc=captured address). If a new request is accepted in the same cycle, stay in WAIT; otherwise go to IDLE.
    - On `imem_rvalid` with `stall`=1: write data and PC to the hold buffer and go to HOLD.
  - HOLD: response buffered. No requests issued. When `stall`=0, move the buffer into IF/ID with valid=1 and go to IDLE.
- IF/ID update priority, per cycle:
  1. `redirect_valid` loads a bubble (inst=NOP_INST, valid=0, pc unchanged). This applies even when `stall`=1.
  2. `stall` holds all IF/ID outputs.
  3. New instruction delivered: load it.
  4. Otherwise load a bubble.
- Redirect handling:
  - `pc_q <= {redirect_pc[31:2],2'b00}`. This overrides any increment.
  - In HOLD: empty the hold buffer and go to IDLE.
  - In WAIT with no `imem_rvalid` this cycle: set `discard`=1 and stay in WAIT.
  - In WAIT with `imem_rvalid` this cycle: drop the response and go to IDLE.
  - A redirect while `discard` is already set leaves `discard`=1.
- `imem_rvalid` outside WAIT is a protocol error. It is ignored.

## Timing

- Fetch latency: request accepted in cycle N, `imem_rvalid` in N+1, `IF_ID_valid`=1 from N+2.
- Throughput with a zero-wait memory (`imem_ready`=1, rvalid one cycle after accept): one instruction per cycle in steady state.
- Redirect in cycle N: the bubble is visible in N+1, and `imem_req` may assert with `imem_addr`=redirect target in N+1.
- A stall holds IF/ID with zero-cycle reaction. The buffered instruction appears in IF/ID the cycle after `stall` drops.
- Reset assertion mid-fetch aborts immediately. Any late `imem_rvalid` after reset release is ignored (state is IDLE).

## Test plan

- Reset with RESET_PC=0x100, zero-wait memory returning `addr ^ 0xA5A5_0000`: the first request is at 0x100. IF/ID shows pc 0x100, 0x104, 0x108 in consecutive cycles, and inst matches.
- Assert `stall` for 3 cycles mid-stream: IF/ID holds its value, `imem_req` stays low after the buffered response, no instruction is lost or duplicated, and the sequence resumes in order.
- Redirect to 0x2002 while in WAIT, with rvalid 2 cycles later: the late response is discarded, the next request is 0x2000, and `IF_ID_valid`=0 for exactly the flush cycle plus the fetch latency.
- Redirect and `imem_rvalid` in the same cycle, with `stall`=1: IF/ID becomes NOP/valid=0, the data is dropped, and the next request is at the target.
- Set `pc_q` to 0xFFFF_FFFC via redirect: the fetches are 0xFFFF_FFFC then 0x0000_0000.
- Deassert `rst_n` while in WAIT, then pulse `imem_rvalid` after release: the outputs return to reset values, the stray rvalid is ignored, and fetch restarts at RESET_PC.
